// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Moore FSM that drives a dripper valve and a sprinkler valve from soil and
//   tank sensors. Valves stay open for at least MIN_ON_CYCLES and at most
//   MAX_ON_CYCLES. After irrigation a COOLDOWN phase of COOLDOWN_CYCLES
//   follows. An empty tank forces the FAULT state.
//
//   Build option: define IRRIGATION_FAULT_LATCH_EN to latch FAULT until a
//   fault_clear pulse arrives with the tank no longer empty. Without it, FAULT
//   falls back to COOLDOWN as soon as tank_empty drops, and fault_clear is
//   ignored.
//
//   Ports
//     clock          in   system clock, rising edge
//     reset          in   synchronous, active-high
//     enable         in   irrigation permitted
//     soil_dry       in   soil needs water
//     soil_critical  in   soil severely dry, sprinkler requested
//     tank_low       in   water level low, sprinkler forbidden
//     tank_empty     in   no water, all valves closed
//     fault_clear    in   single-cycle fault acknowledge
//     irrigation_on  out  any valve open
//     splinker_on    out  sprinkler valve open
//     dripper_on     out  dripper valve open
//     error          out  FAULT state active
//     state_code     out  0 IDLE, 1 DRIP, 2 SPRINKLE, 3 COOLDOWN, 4 FAULT
module irrigation_scheduler #(
   parameter int unsigned MIN_ON_CYCLES   = 4,
   parameter int unsigned MAX_ON_CYCLES   = 20,
   parameter int unsigned COOLDOWN_CYCLES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       soil_dry,
   input  logic       soil_critical,
   input  logic       tank_low,
   input  logic       tank_empty,
   input  logic       fault_clear,
   output logic       irrigation_on,
   output logic       splinker_on,
   output logic       dripper_on,
   output logic       error,
   output logic [2:0] state_code
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRIP     = 3'd1,
      ST_SPRINKLE = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   localparam logic [15:0] MIN_LAST  = 16'(MIN_ON_CYCLES - 1);
   localparam logic [15:0] MAX_LAST  = 16'(MAX_ON_CYCLES - 1);
   localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] count;
   logic [15:0] count_nxt;
   logic        keep_count;

`ifndef IRRIGATION_FAULT_LATCH_EN
   logic fault_clear_unused;
   assign fault_clear_unused = fault_clear;
`endif

   always_comb begin
      state_nxt  = state;
      keep_count = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tank_empty)
               state_nxt = ST_FAULT;
            else if (enable && soil_critical && !tank_low)
               state_nxt = ST_SPRINKLE;
            else if (enable && soil_dry)
               state_nxt = ST_DRIP;
         end
         ST_DRIP, ST_SPRINKLE: begin
            if (tank_empty)
               state_nxt = ST_FAULT;
            else if (!enable)
               state_nxt = ST_COOLDOWN;
            else if (count == MAX_LAST)
               state_nxt = ST_COOLDOWN;
            else if (!soil_dry && (count >= MIN_LAST))
               state_nxt = ST_COOLDOWN;
            else if ((state == ST_SPRINKLE) && tank_low) begin
               // Counter carries over so the watchdog bounds total open time.
               state_nxt  = ST_DRIP;
               keep_count = 1'b1;
            end
         end
         ST_COOLDOWN: begin
            if (tank_empty)
               state_nxt = ST_FAULT;
            else if (count == COOL_LAST)
               state_nxt = ST_IDLE;
         end
         ST_FAULT: begin
`ifdef IRRIGATION_FAULT_LATCH_EN
            if (fault_clear && !tank_empty)
               state_nxt = ST_IDLE;
`else
            if (!tank_empty)
               state_nxt = ST_COOLDOWN;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase

      if ((state_nxt != state) && !keep_count)
         count_nxt = '0;
      else if (count == 16'hFFFF)
         count_nxt = count;
      else
         count_nxt = count + 16'd1;
   end

   // Outputs are registered from the next state so they track the state
   // register exactly, without a decode stage after the flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         count         <= '0;
         irrigation_on <= 1'b0;
         splinker_on   <= 1'b0;
         dripper_on    <= 1'b0;
         error         <= 1'b0;
         state_code    <= '0;
      end else begin
         state         <= state_nxt;
         count         <= count_nxt;
         irrigation_on <= (state_nxt == ST_DRIP) || (state_nxt == ST_SPRINKLE);
         splinker_on   <= (state_nxt == ST_SPRINKLE);
         dripper_on    <= (state_nxt == ST_DRIP);
         error         <= (state_nxt == ST_FAULT);
         state_code    <= state_nxt;
      end
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;

   localparam int MIN_ON  = 4;
   localparam int MAX_ON  = 20;
   localparam int COOL    = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       soil_dry = 1'b0;
   logic       soil_critical = 1'b0;
   logic       tank_low = 1'b0;
   logic       tank_empty = 1'b0;
   logic       fault_clear = 1'b0;
   logic       irrigation_on;
   logic       splinker_on;
   logic       dripper_on;
   logic       error;
   logic [2:0] state_code;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   irrigation_scheduler #(
      .MIN_ON_CYCLES  (MIN_ON),
      .MAX_ON_CYCLES  (MAX_ON),
      .COOLDOWN_CYCLES(COOL)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .soil_dry     (soil_dry),
      .soil_critical(soil_critical),
      .tank_low     (tank_low),
      .tank_empty   (tank_empty),
      .fault_clear  (fault_clear),
      .irrigation_on(irrigation_on),
      .splinker_on  (splinker_on),
      .dripper_on   (dripper_on),
      .error        (error),
      .state_code   (state_code)
   );

   always #5 clock = ~clock;

   // Reference model: phase plus elapsed-cycle counts of the current open
   // period (open_n) and cooldown period (cool_n), both counting from 1.
   int m_mode = 0;   // 0 idle, 1 drip, 2 sprinkle, 3 cooldown, 4 fault
   int open_n = 0;
   int cool_n = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_mode = 0;
         open_n = 0;
         cool_n = 0;
      end else if (m_mode != 4 && tank_empty) begin
         m_mode = 4;
      end else begin
         case (m_mode)
            0: begin
               if (enable && soil_critical && !tank_low) begin
                  m_mode = 2; open_n = 1;
               end else if (enable && soil_dry) begin
                  m_mode = 1; open_n = 1;
               end
            end
            1, 2: begin
               if (!enable || open_n == MAX_ON || (!soil_dry && open_n >= MIN_ON)) begin
                  m_mode = 3; cool_n = 1;
               end else begin
                  if (m_mode == 2 && tank_low) m_mode = 1;
                  open_n++;
               end
            end
            3: begin
               if (cool_n == COOL) m_mode = 0;
               else cool_n++;
            end
            default: begin
`ifdef IRRIGATION_FAULT_LATCH_EN
               if (fault_clear && !tank_empty) m_mode = 0;
`else
               if (!tank_empty) begin
                  m_mode = 3; cool_n = 1;
               end
`endif
            end
         endcase
      end
   end

   function automatic logic [6:0] expect_vec(input int mode);
      logic [6:0] v;
      v[6]   = (mode == 1 || mode == 2);
      v[5]   = (mode == 2);
      v[4]   = (mode == 1);
      v[3]   = (mode == 4);
      v[2:0] = 3'(mode);
      return v;
   endfunction

   logic [6:0] dut_vec;
   assign dut_vec = {irrigation_on, splinker_on, dripper_on, error, state_code};

   always @(negedge clock) begin
      if (chk_en) begin
         vectors++;
         if (dut_vec !== expect_vec(m_mode)) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t dut={irr,spr,drp,err,code}=%b expected=%b",
                     $time, dut_vec, expect_vec(m_mode));
         end
      end
   end

   task automatic check_lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   // Counts consecutive cycles showing the given state code, bounded.
   task automatic measure(input logic [2:0] code, output int n);
      n = 0;
      while (state_code == code && n < 200) begin
         n++;
         cyc();
      end
   endtask

   task automatic clear_inputs();
      enable = 0; soil_dry = 0; soil_critical = 0;
      tank_low = 0; tank_empty = 0; fault_clear = 0;
   endtask

   initial begin
      int n;
      int m;

      reset = 1'b1;
      cyc();
      chk_en = 1'b1;
      check_lit("reset_outputs", int'(dut_vec), 0);
      reset = 1'b0;
      cyc();

      // Drip cycle
      enable = 1; soil_dry = 1;
      cyc();
      check_lit("s1_enter_drip", int'(state_code), 1);
      cyc();
      soil_dry = 0;
      measure(3'd1, m);
      check_lit("s1_drip_len", m + 1, MIN_ON);
      measure(3'd3, n);
      check_lit("s1_cool_len", n, COOL);
      check_lit("s1_idle", int'(state_code), 0);

      // Sprinkler watchdog
      enable = 1; soil_critical = 1; soil_dry = 1;
      cyc();
      measure(3'd2, n);
      check_lit("s2_spr_len", n, MAX_ON);
      check_lit("s2_cool_after", int'(state_code), 3);
      soil_critical = 0; soil_dry = 0;
      measure(3'd3, n);

      // Tank low during sprinkler
      soil_critical = 1; soil_dry = 1;
      cyc();
      check_lit("s3_enter_spr", int'(state_code), 2);
      for (int i = 0; i < 6; i++) cyc();
      tank_low = 1;
      cyc();
      check_lit("s3_handover", int'(state_code), 1);
      measure(3'd1, m);
      check_lit("s3_total_open", 7 + m, MAX_ON);
      clear_inputs();
      measure(3'd3, n);

      // Tank empty during drip
      enable = 1; soil_dry = 1;
      cyc();
      cyc();
      tank_empty = 1;
      cyc();
      check_lit("s4_fault_outs", int'(dut_vec), 7'b0001100);
      fault_clear = 1;
      cyc();
      check_lit("s4_clear_ignored", int'(state_code), 4);
      fault_clear = 0; tank_empty = 0; enable = 0; soil_dry = 0;
      cyc();
`ifdef IRRIGATION_FAULT_LATCH_EN
      check_lit("s4_latched", int'(state_code), 4);
      fault_clear = 1;
      cyc();
      fault_clear = 0;
      check_lit("s4_cleared_idle", int'(state_code), 0);
`else
      check_lit("s4_auto_cool", int'(state_code), 3);
      measure(3'd3, n);
      check_lit("s4_cool_len", n, COOL);
`endif

      // Reset mid-sprinkle
      enable = 1; soil_critical = 1; soil_dry = 1;
      cyc();
      cyc();
      cyc();
      reset = 1;
      cyc();
      check_lit("s5_reset_outs", int'(dut_vec), 0);
      reset = 0;
      cyc();
      check_lit("s5_reenter", int'(state_code), 2);
      measure(3'd2, n);
      check_lit("s5_fresh_len", n, MAX_ON);
      clear_inputs();
      measure(3'd3, n);

      // Randomized phase with persistent inputs
      enable = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) enable = ~enable;
         if ($urandom_range(0, 5) == 0)  soil_dry = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0)  soil_critical = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0)  tank_low = ($urandom_range(0, 3) == 0);
         if (tank_empty) tank_empty = ($urandom_range(0, 4) != 0);
         else            tank_empty = ($urandom_range(0, 59) == 0);
         fault_clear = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 249) == 0);
         cyc();
      end

      clear_inputs();
      reset = 0;
      for (int i = 0; i < 30; i++) cyc();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter MIN_ON_CYCLES, default 4: minimum cycles a valve stays open once opened; range 1..65535.
REQ-002 Parameter MAX_ON_CYCLES, default 20: watchdog limit on continuous open time; MIN_ON_CYCLES <= MAX_ON_CYCLES <= 65535.
REQ-003 Parameter COOLDOWN_CYCLES, default 3: closed-valve settle time after irrigation; range 1..65535.
REQ-004 Ports, in this order:
  - clock  in  1  single system clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - enable  in  1  irrigation permitted.
  - soil_dry  in  1  soil needs water.
  - soil_critical  in  1  soil severely dry; sprinkler requested.
  - tank_low  in  1  water level low; sprinkler forbidden.
  - tank_empty  in  1  no water; all valves must close.
  - fault_clear  in  1  single-cycle fault acknowledge.
  - irrigation_on  out  1  any valve open.
  - splinker_on  out  1  sprinkler valve open.
  - dripper_on  out  1  dripper valve open.
  - error  out  1  fault state active.
  - state_code  out  3  current state: 0 IDLE, 1 DRIP, 2 SPRINKLE, 3 COOLDOWN, 4 FAULT.

Function
REQ-005 The block SHALL be a Moore FSM with states IDLE, DRIP, SPRINKLE, COOLDOWN, FAULT; all outputs are decoded from the registered state only, so each response appears the cycle after the sampling edge.
REQ-006 Output decode SHALL be: DRIP -> dripper_on=1, irrigation_on=1; SPRINKLE -> splinker_on=1, irrigation_on=1; FAULT -> error=1; all other outputs 0; splinker_on and dripper_on never both 1.
REQ-007 A 16-bit counter SHALL clear to 0 on every state change and increment in each cycle the state is held; it saturates at 65535.
REQ-008 Transition priority, evaluated every edge: tank_empty first, then the state-specific rules below.
REQ-009 From any state except FAULT, tank_empty=1 SHALL select FAULT.
REQ-010 IDLE: enable & soil_critical & !tank_low -> SPRINKLE; otherwise enable & soil_dry -> DRIP; otherwise stay.
REQ-011 DRIP/SPRINKLE: enable=0 -> COOLDOWN immediately, ignoring MIN_ON_CYCLES.
REQ-012 DRIP/SPRINKLE: counter == MAX_ON_CYCLES-1 -> COOLDOWN, so a valve is never open more than MAX_ON_CYCLES cycles.
REQ-013 DRIP/SPRINKLE: soil_dry=0 and counter >= MIN_ON_CYCLES-1 -> COOLDOWN; soil_dry=0 earlier holds the state.
REQ-014 SPRINKLE with tank_low=1 -> DRIP; the counter is not cleared on this transition, so open time accumulates across the handover.
REQ-015 DRIP does not upgrade to SPRINKLE; soil_critical is sampled only in IDLE.
REQ-016 COOLDOWN: counter == COOLDOWN_CYCLES-1 -> IDLE, giving exactly COOLDOWN_CYCLES cycles in COOLDOWN.
REQ-017 FAULT exit follows REQ-023.
REQ-018 Invalid state encodings 5-7 SHALL go to IDLE on the next edge.

Reset
REQ-019 reset=1 at a rising edge SHALL force IDLE and counter 0, overriding all other inputs, including mid-irrigation and in FAULT.
REQ-020 In the cycle after reset, all outputs SHALL be 0 and state_code SHALL be 0.
REQ-021 There SHALL be no asynchronous reset path.

Configuration
REQ-022 The macro IRRIGATION_FAULT_LATCH_EN SHALL select the fault recovery mode.
REQ-023 With IRRIGATION_FAULT_LATCH_EN defined: FAULT goes to IDLE only when fault_clear=1 and tank_empty=0 at the same edge; fault_clear while tank_empty=1 is ignored. Without the macro: FAULT goes to COOLDOWN at the first edge with tank_empty=0, and fault_clear is unused.

Verification
REQ-024 With default parameters, the bench SHALL cover these scenarios:
  - Scenario 1, drip cycle. Stimulus: enable=1, soil_dry=1 for 2 cycles, then 0. Response: dripper_on high for exactly 4 cycles, then COOLDOWN for 3 cycles, then IDLE.
  - Scenario 2, sprinkler watchdog. Stimulus: enable=1, soil_critical=1, soil_dry=1 held. Response: splinker_on high for exactly 20 cycles, then state_code=3.
  - Scenario 3, tank low during sprinkler. Stimulus: tank_low rises at counter=6 in SPRINKLE, soil_dry held. Response: DRIP next cycle, and total open time ends at 20 cycles.
  - Scenario 4, tank empty with the macro defined. Stimulus: tank_empty pulses in DRIP. Response: all valves 0 and error=1 next cycle; fault_clear while tank_empty=1 has no effect; fault_clear after tank_empty=0 gives IDLE. Without the macro, the response is COOLDOWN on the first edge with tank_empty=0.
  - Scenario 5, reset mid-operation. Stimulus: reset=1 at counter=2 in SPRINKLE, with soil inputs still active. Response: all outputs 0 next cycle, and a fresh IDLE->SPRINKLE entry one edge after reset is released.
